// File: rtl/sudoku_grid_checker_pkg.sv
// sudoku_pkg: checker FSM states, error codes and box-pass cell addressing
//   state_t  : IDLE, ROWS, COLS, BOXES
//   ERR_*    : err_kind encodings
//   box_cell : (row, col) of position p inside box u for a given box side
package sudoku_pkg;
  typedef enum logic [1:0] {IDLE, ROWS, COLS, BOXES} state_t;
  localparam logic [1:0] ERR_ROW = 2'd0;
  localparam logic [1:0] ERR_COL = 2'd1;
  localparam logic [1:0] ERR_BOX = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
  } cell_t;
  function automatic cell_t box_cell(input int box, input logic [3:0] u, input logic [3:0] p);
    cell_t x;
    x.r = 4'((int'(u) / box) * box + int'(p) / box);
    x.c = 4'((int'(u) % box) * box + int'(p) % box);
    return x;
  endfunction
endpackage

// File: rtl/sudoku_grid_checker_if.sv
// sudoku_grid_checker_if: load stream, check control and status bundle
//   master : drives load_valid/load_value/load_restart/check_start, sees status
//   slave  : the checker side
interface sudoku_grid_checker_if #(
  parameter int BOX = 3
);
  localparam int N = BOX * BOX;
  localparam int DW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  logic          load_valid;
  logic [DW-1:0] load_value;
  logic          load_ready;
  logic          load_restart;
  logic          check_start;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_kind;
  logic [IW-1:0] err_index;
  logic          loaded_full;
  modport master (
    output load_valid, load_value, load_restart, check_start,
    input  load_ready, busy, done, err, err_kind, err_index, loaded_full
  );
  modport slave (
    input  load_valid, load_value, load_restart, check_start,
    output load_ready, busy, done, err, err_kind, err_index, loaded_full
  );
endinterface

// File: rtl/sudoku_unit_tracker.sv
// sudoku_unit_tracker: seen-digit mask for one row/column/box unit
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : a cell is being examined this cycle
//   clr_i       : first cell of a unit; the mask is treated as empty
//   value_i     : cell value (0 empty, 1..N digit, >N out of range)
//   dup_o       : digit already seen in this unit
//   range_err_o : value exceeds N
module sudoku_unit_tracker #(
  parameter int N  = 9,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] value_i,
  output logic          dup_o,
  output logic          range_err_o
);
  logic [N-1:0] mask_q, mask_d, base, hit;
  logic digit;
  always_comb begin
    digit = value_i != '0 && value_i <= DW'(N);
    hit = digit ? N'(1) << (value_i - DW'(1)) : '0;
    base = clr_i ? '0 : mask_q;
    dup_o = en_i && |(base & hit);
    range_err_o = en_i && value_i > DW'(N);
    mask_d = en_i ? base | hit : mask_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask_q <= '0;
    else mask_q <= mask_d;
endmodule

// File: rtl/sudoku_grid_checker.sv
// sudoku_grid_checker: N x N grid store with row, column and box validation
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load stream (load_valid/value/ready/restart), check_start,
//                status (busy, done, err, err_kind, err_index, loaded_full)
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter int BOX = 3
) (
  input logic clk,
  input logic rst_n,
  sudoku_grid_checker_if.slave bus
);
  localparam int N = BOX * BOX;
  localparam int DW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N * N);
  state_t state_q, state_d;
  logic [IW-1:0] u_q, u_d, p_q, p_d, row_q, row_d, col_q, col_d, idx_q, idx_d, sr, sc;
  logic [1:0] kind_q, kind_d;
  logic full_q, full_d, done_q, done_d, err_q, err_d;
  logic busy, wr, dup, range_err, p_last, u_last;
  logic [DW-1:0] grid_q [N*N];
  logic [DW-1:0] scan_val;
  logic [CW-1:0] scan_idx, wr_idx;
  cell_t bc;
  assign busy = state_q != IDLE;
  assign p_last = p_q == IW'(N - 1);
  assign u_last = u_q == IW'(N - 1);
  assign bc = box_cell(BOX, 4'(u_q), 4'(p_q));
  // unit u / position p mapped to (row, col) for the current pass
  assign sr = state_q == COLS ? p_q : state_q == BOXES ? IW'(bc.r) : u_q;
  assign sc = state_q == COLS ? u_q : state_q == BOXES ? IW'(bc.c) : p_q;
  assign scan_idx = CW'(sr) * CW'(N) + CW'(sc);
  assign wr_idx = CW'(row_q) * CW'(N) + CW'(col_q);
  assign scan_val = grid_q[scan_idx];
  sudoku_unit_tracker #(.N(N), .DW(DW)) u_trk (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(busy),
    .clr_i(p_q == '0),
    .value_i(scan_val),
    .dup_o(dup),
    .range_err_o(range_err)
  );
  always_comb begin
    state_d = state_q;
    u_d = u_q;
    p_d = p_q;
    row_d = row_q;
    col_d = col_q;
    full_d = full_q;
    done_d = done_q;
    err_d = err_q;
    kind_d = kind_q;
    idx_d = idx_q;
    wr = 1'b0;
    if (bus.load_restart) begin
      row_d = '0;
      col_d = '0;
      full_d = 1'b0;
    end else if (bus.load_valid && !busy) begin
      wr = 1'b1;
      col_d = col_q == IW'(N - 1) ? '0 : col_q + IW'(1);
      row_d = col_q != IW'(N - 1) ? row_q : row_q == IW'(N - 1) ? '0 : row_q + IW'(1);
      full_d = full_q || (row_q == IW'(N - 1) && col_q == IW'(N - 1));
    end
    if (!busy) begin
      if (bus.check_start) begin
        state_d = ROWS;
        u_d = '0;
        p_d = '0;
        done_d = 1'b0;
        err_d = 1'b0;
        kind_d = ERR_ROW;
        idx_d = '0;
      end
    end else begin
      // only the first error is kept; the scan runs to completion regardless
      if ((dup || range_err) && !err_q) begin
        err_d = 1'b1;
        kind_d = range_err ? ERR_RANGE : state_q == ROWS ? ERR_ROW : state_q == COLS ? ERR_COL : ERR_BOX;
        idx_d = u_q;
      end
      p_d = p_last ? '0 : p_q + IW'(1);
      u_d = !p_last ? u_q : u_last ? '0 : u_q + IW'(1);
      if (p_last && u_last) begin
        state_d = state_q == ROWS ? COLS : state_q == COLS ? BOXES : IDLE;
        done_d = state_q == BOXES;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      u_q <= '0;
      p_q <= '0;
      row_q <= '0;
      col_q <= '0;
      full_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      kind_q <= ERR_ROW;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      u_q <= u_d;
      p_q <= p_d;
      row_q <= row_d;
      col_q <= col_d;
      full_q <= full_d;
      done_q <= done_d;
      err_q <= err_d;
      kind_q <= kind_d;
      idx_q <= idx_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N * N; i++) grid_q[i] <= '0;
    else if (wr) grid_q[wr_idx] <= bus.load_value;
  assign bus.load_ready = !busy;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.err_kind = kind_q;
  assign bus.err_index = idx_q;
  assign bus.loaded_full = full_q;
endmodule

// File: tb/tb_sudoku_grid_checker.sv
// tb_sudoku_grid_checker: randomized checks of BOX=3 and BOX=2 checkers against a grid-rule model
module tb_sudoku_grid_checker;
  typedef int grid_t [16][16];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sudoku_grid_checker_if #(.BOX(3)) i3();
  sudoku_grid_checker_if #(.BOX(2)) i2();
  sudoku_grid_checker #(.BOX(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  sudoku_grid_checker #(.BOX(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  task automatic set_in(input int box, input logic v, input int val, input logic rs, input logic st);
    if (box == 3) begin
      i3.load_valid = v; i3.load_value = 4'(val); i3.load_restart = rs; i3.check_start = st;
    end else begin
      i2.load_valid = v; i2.load_value = 3'(val); i2.load_restart = rs; i2.check_start = st;
    end
  endtask

  task automatic get_out(input int box, output int b, output int d, output int e, output int k,
                         output int ix, output int f, output int rd);
    if (box == 3) begin
      b = int'(i3.busy); d = int'(i3.done); e = int'(i3.err); k = int'(i3.err_kind);
      ix = int'(i3.err_index); f = int'(i3.loaded_full); rd = int'(i3.load_ready);
    end else begin
      b = int'(i2.busy); d = int'(i2.done); e = int'(i2.err); k = int'(i2.err_kind);
      ix = int'(i2.err_index); f = int'(i2.loaded_full); rd = int'(i2.load_ready);
    end
  endtask

  // rows, then columns, then boxes; first duplicate or out-of-range value wins
  task automatic model(input int box, input grid_t g, output int e, output int k, output int ix);
    int n, r, c, v;
    bit seen [17];
    n = box * box;
    e = 0; k = 0; ix = 0;
    for (int pass = 0; pass < 3; pass++)
      for (int u = 0; u < n; u++) begin
        for (int i = 0; i < 17; i++) seen[i] = 0;
        for (int p = 0; p < n; p++) begin
          if (pass == 0) begin r = u; c = p; end
          else if (pass == 1) begin r = p; c = u; end
          else begin r = (u / box) * box + p / box; c = (u % box) * box + p % box; end
          v = g[r][c];
          if (v > n) begin
            if (e == 0) begin e = 1; k = 3; ix = u; end
          end else if (v != 0) begin
            if (seen[v] && e == 0) begin e = 1; k = pass; ix = u; end
            seen[v] = 1;
          end
        end
      end
  endtask

  task automatic solved(input int box, output grid_t g);
    int perm [16];
    int n, j, t;
    n = box * box;
    g = '{default: 0};
    for (int i = 0; i < 16; i++) perm[i] = i + 1;
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) g[r][c] = perm[(box * (r % box) + r / box + c) % n];
  endtask

  task automatic load(input int box, input grid_t g);
    set_in(box, 0, 0, 1, 0);
    @(negedge clk);
    for (int r = 0; r < box * box; r++)
      for (int c = 0; c < box * box; c++) begin
        set_in(box, 1, g[r][c], 0, 0);
        @(negedge clk);
      end
    set_in(box, 0, 0, 0, 0);
  endtask

  // pulses check_start and counts busy cycles; disturb pokes check_start/load_valid mid-check
  task automatic run(input int box, input bit disturb, output int cnt, output int rdy_hi);
    int b, d, e, k, ix, f, rd;
    cnt = 0; rdy_hi = 0;
    set_in(box, 0, 0, 0, 1);
    @(negedge clk);
    set_in(box, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      get_out(box, b, d, e, k, ix, f, rd);
      if (b == 0 && cnt > 0) break;
      if (b != 0) begin cnt++; if (rd != 0) rdy_hi++; end
      if (disturb) set_in(box, cnt >= 20 && cnt < 30, 5, 0, cnt >= 20 && cnt < 30);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int b, d, e, k, ix, f, rd;
    for (int box = 2; box <= 3; box++) begin
      get_out(box, b, d, e, k, ix, f, rd);
      checks++;
      if (b !== 0 || d !== 0 || e !== 0 || k !== 0 || ix !== 0 || f !== 0 || rd !== 1) begin
        errors++;
        $display("FAIL reset box%0d: busy=%0d done=%0d err=%0d kind=%0d idx=%0d full=%0d ready=%0d, expected 0 0 0 0 0 0 1",
                 box, b, d, e, k, ix, f, rd);
      end
    end
  endtask

  task automatic test_zero_and_range();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    g = '{default: 0};
    model(3, g, me, mk, mi);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 243 || d !== 1 || e !== me) begin
      errors++;
      $display("FAIL zero_grid: cycles=%0d done=%0d err=%0d, expected 243 1 %0d", cnt, d, e, me);
    end
    g[0][0] = 10;
    model(3, g, me, mk, mi);
    set_in(3, 0, 0, 1, 0); @(negedge clk);
    set_in(3, 1, 10, 0, 0); @(negedge clk);
    set_in(3, 0, 0, 0, 0);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (d !== 1 || e !== me || k !== mk || ix !== mi || f !== 0) begin
      errors++;
      $display("FAIL range: done=%0d err=%0d kind=%0d idx=%0d full=%0d, expected 1 %0d %0d %0d 0", d, e, k, ix, f, me, mk, mi);
    end
  endtask

  task automatic test_valid_grid();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    for (int t = 0; t < 2; t++) begin
      solved(3, g);
      model(3, g, me, mk, mi);
      load(3, g);
      get_out(3, b, d, e, k, ix, f, rd);
      checks++;
      if (f !== 1) begin errors++; $display("FAIL valid_full: loaded_full=%0d expected 1", f); end
      run(3, 0, cnt, rh);
      get_out(3, b, d, e, k, ix, f, rd);
      checks++;
      if (cnt !== 243 || d !== 1 || e !== me) begin
        errors++;
        $display("FAIL valid_grid: cycles=%0d done=%0d err=%0d, expected 243 1 %0d", cnt, d, e, me);
      end
    end
  endtask

  task automatic test_row_dup();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    solved(3, g);
    g[4][7] = g[4][2];
    model(3, g, me, mk, mi);
    load(3, g);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 243 || d !== 1 || e !== me || k !== mk || ix !== mi) begin
      errors++;
      $display("FAIL row_dup: cycles=%0d done=%0d err=%0d kind=%0d idx=%0d, expected 243 1 %0d %0d %0d",
               cnt, d, e, k, ix, me, mk, mi);
    end
  endtask

  task automatic test_box_dup();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi, t;
    g = '{default: 0};
    for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) g[r][c] = (r + c) % 9 + 1;
    model(3, g, me, mk, mi);
    load(3, g);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (d !== 1 || e !== me || k !== mk || ix !== mi) begin
      errors++;
      $display("FAIL box_dup: done=%0d err=%0d kind=%0d idx=%0d, expected 1 %0d %0d %0d", d, e, k, ix, me, mk, mi);
    end
    solved(3, g);
    for (int r = 0; r < 3; r++) begin t = g[r][0]; g[r][0] = g[r][1]; g[r][1] = t; end
    model(3, g, me, mk, mi);
    load(3, g);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (d !== 1 || e !== me || k !== mk || ix !== mi) begin
      errors++;
      $display("FAIL col_swap: done=%0d err=%0d kind=%0d idx=%0d, expected 1 %0d %0d %0d", d, e, k, ix, me, mk, mi);
    end
  endtask

  task automatic test_random_faults();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    for (int t = 0; t < 4; t++) begin
      solved(3, g);
      g[$urandom_range(8, 0)][$urandom_range(8, 0)] = $urandom_range(15, 0);
      if (t == 3) g[$urandom_range(8, 0)][$urandom_range(8, 0)] = $urandom_range(9, 1);
      model(3, g, me, mk, mi);
      load(3, g);
      run(3, 0, cnt, rh);
      get_out(3, b, d, e, k, ix, f, rd);
      checks++;
      if (cnt !== 243 || e !== me || (me == 1 && (k !== mk || ix !== mi))) begin
        errors++;
        $display("FAIL random_fault%0d: cycles=%0d err=%0d kind=%0d idx=%0d, expected 243 %0d %0d %0d",
                 t, cnt, e, k, ix, me, mk, mi);
      end
    end
  endtask

  task automatic test_busy_lockout();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    solved(3, g);
    model(3, g, me, mk, mi);
    load(3, g);
    run(3, 1, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 243 || rh !== 0) begin
      errors++;
      $display("FAIL busy_lockout: cycles=%0d ready_while_busy=%0d, expected 243 0", cnt, rh);
    end
    checks++;
    if (d !== 1 || e !== me) begin
      errors++;
      $display("FAIL busy_grid_kept: done=%0d err=%0d, expected 1 %0d", d, e, me);
    end
  endtask

  task automatic test_reset_midcheck();
    grid_t g;
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    solved(3, g);
    g[2][5] = g[2][0];
    load(3, g);
    set_in(3, 0, 0, 0, 1); @(negedge clk);
    set_in(3, 0, 0, 0, 0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (b !== 0 || d !== 0 || e !== 0 || f !== 0 || rd !== 1) begin
      errors++;
      $display("FAIL reset_mid: busy=%0d done=%0d err=%0d full=%0d ready=%0d, expected 0 0 0 0 1", b, d, e, f, rd);
    end
    rst_n = 1'b1;
    @(negedge clk);
    g = '{default: 0};
    model(3, g, me, mk, mi);
    run(3, 0, cnt, rh);
    get_out(3, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 243 || d !== 1 || e !== me) begin
      errors++;
      $display("FAIL reset_cleared: cycles=%0d done=%0d err=%0d, expected 243 1 %0d", cnt, d, e, me);
    end
  endtask

  task automatic test_box2();
    grid_t g, v;
    int rows [4][4] = '{'{1, 2, 3, 4}, '{3, 2, 1, 4}, '{2, 3, 4, 1}, '{4, 2, 1, 3}};
    int cnt, rh, b, d, e, k, ix, f, rd, me, mk, mi;
    g = '{default: 0};
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) g[r][c] = rows[r][c];
    model(2, g, me, mk, mi);
    load(2, g);
    run(2, 0, cnt, rh);
    get_out(2, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 48 || d !== 1 || e !== me || k !== mk || ix !== mi || f !== 1) begin
      errors++;
      $display("FAIL box2_col: cycles=%0d done=%0d err=%0d kind=%0d idx=%0d full=%0d, expected 48 1 %0d %0d %0d 1",
               cnt, d, e, k, ix, f, me, mk, mi);
    end
    solved(2, v);
    model(2, v, me, mk, mi);
    load(2, v);
    set_in(2, 1, v[0][0], 0, 0); @(negedge clk);
    set_in(2, 1, v[0][1], 0, 0); @(negedge clk);
    set_in(2, 1, 7, 1, 0); @(negedge clk);
    set_in(2, 0, 0, 0, 0);
    get_out(2, b, d, e, k, ix, f, rd);
    checks++;
    if (f !== 0) begin errors++; $display("FAIL restart_full: loaded_full=%0d expected 0", f); end
    set_in(2, 1, v[0][0], 0, 0); @(negedge clk);
    set_in(2, 0, 0, 0, 0);
    run(2, 0, cnt, rh);
    get_out(2, b, d, e, k, ix, f, rd);
    checks++;
    if (cnt !== 48 || d !== 1 || e !== me) begin
      errors++;
      $display("FAIL restart_nowrite: cycles=%0d done=%0d err=%0d kind=%0d idx=%0d, expected 48 1 %0d",
               cnt, d, e, k, ix, me);
    end
  endtask

  initial begin
    set_in(3, 0, 0, 0, 0);
    set_in(2, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_and_range();
    test_valid_grid();
    test_row_dup();
    test_box_dup();
    test_random_faults();
    test_busy_lockout();
    test_reset_midcheck();
    test_box2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
